div_arbiter: RTL and testbench

Shares one multi-cycle signed divider among `N_REQ` requesters, for example the demodulator's `qarctan` and the de-emphasis or stereo-balance stages of the FM radio pipeline. Arbitration is round-robin and each requester sees a valid/ready handshake. The block sequences the divider by latching operands, pulsing start, waiting for done and returning the quotient to the granted requester. Divide-by-zero is resolved locally without starting the divider.

---
 rtl/div_arbiter_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/div_arbiter.sv | 123 ++++++++++++
 tb/tb_div_arbiter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared types and helpers for the divider arbiter: FSM state encoding and
// the divide-by-zero saturation value.
package div_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } div_arb_state_t;

    localparam int SAT_MAX_W = 64;

    // Most negative value for a negative dividend, most positive otherwise,
    // for an operand of `width` bits; callers truncate to their own width.
    function automatic logic [SAT_MAX_W-1:0] sat_quotient(
        input logic [SAT_MAX_W-1:0] dividend,
        input int                   width
    );
        logic [SAT_MAX_W-1:0] sign_bit;
        sign_bit = SAT_MAX_W'(1) << (width - 1);
        if ((dividend & sign_bit) != '0) begin
            return sign_bit;
        end
        return sign_bit - SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping around; one-hot grant plus an any-request flag.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one external multi-cycle signed divider between
// N_REQ requesters; divide-by-zero is answered locally with saturation.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_dividend,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_divisor,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_quotient,
    output logic                        rsp_dbz,
    output logic                        div_start,
    output logic [DATA_WIDTH-1:0]       div_dividend,
    output logic [DATA_WIDTH-1:0]       div_divisor,
    input  logic                        div_done,
    input  logic [DATA_WIDTH-1:0]       div_quotient,
    output logic [1:0]                  dbg_state
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    div_arb_state_t        state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         grant_q;
    logic [PW-1:0]         ptr_next;
    logic [N_REQ-1:0]      win_grant;
    logic                  win_any;
    logic [PW-1:0]         win_idx;
    logic [DATA_WIDTH-1:0] sel_dividend;
    logic [DATA_WIDTH-1:0] sel_divisor;
    logic [DATA_WIDTH-1:0] sat_q;
    logic                  rsp_fire;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .any   (win_any)
    );

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        win_idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_grant[i]) begin
                sel_dividend = req_dividend[i*DATA_WIDTH +: DATA_WIDTH];
                sel_divisor  = req_divisor[i*DATA_WIDTH +: DATA_WIDTH];
                win_idx      = PW'(i);
            end
        end
    end

    // Both channels transfer on valid && ready of the same index; a requester
    // keeps valid and its operands steady until ready, and rsp_valid stays
    // asserted with a stable quotient until the granted rsp_ready.
    assign req_ready = (state == ST_IDLE) ? win_grant : '0;
    assign rsp_fire  = |(rsp_valid & rsp_ready);
    assign sat_q     = DATA_WIDTH'(sat_quotient(SAT_MAX_W'(sel_dividend), DATA_WIDTH));
    assign ptr_next  = (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant_q      <= '0;
            rsp_valid    <= '0;
            rsp_quotient <= '0;
            rsp_dbz      <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        grant_q      <= win_idx;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            rsp_quotient <= sat_q;
                            rsp_dbz      <= 1'b1;
                            rsp_valid    <= win_grant;
                            state        <= ST_RESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    div_start <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (div_done) begin
                        rsp_quotient <= div_quotient;
                        rsp_dbz      <= 1'b0;
                        rsp_valid    <= N_REQ'(1) << grant_q;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        rsp_valid <= '0;
                        rr_ptr    <= ptr_next;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter with three requesters and a behavioural divider of
// programmable latency; round-robin order and quotients come from a model.
module tb_div_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_dividend = '0;
    logic [N*W-1:0] req_divisor  = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '1;
    logic [W-1:0]   rsp_quotient;
    logic           rsp_dbz;
    logic           div_start;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_done;
    logic [W-1:0]   div_quotient;
    logic [1:0]     dbg_state;

    div_arbiter #(.N_REQ(N), .DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_quotient (rsp_quotient),
        .rsp_dbz      (rsp_dbz),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .dbg_state    (dbg_state)
    );

    // ---------------- external divider model ----------------
    int           div_lat     = 4;   // 0 selects a random latency per division
    int           dcnt        = 0;
    logic         dbusy       = 1'b0;
    logic         model_done  = 1'b0;
    logic         inject_done = 1'b0;
    logic [W-1:0] model_q     = '0;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            dbusy      = 1'b0;
            model_done = 1'b0;
            dcnt       = 0;
        end else begin
            model_done = 1'b0;
            if (dbusy) begin
                dcnt--;
                if (dcnt == 0) begin
                    model_done = 1'b1;
                    dbusy      = 1'b0;
                end
            end
            if (div_start) begin
                dbusy   = 1'b1;
                dcnt    = (div_lat > 0) ? div_lat : int'($urandom_range(1, 8));
                model_q = $signed(div_dividend) / $signed(div_divisor);
            end
        end
    end
    assign div_done     = model_done | inject_done;
    assign div_quotient = model_q;

    // ---------------- scoreboard / reference state ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_dbz_q[$];
    int           exp_id_q[$];
    int           grant_log[$];
    int           tests = 0;
    int           failed = 0;
    logic         model_busy = 1'b0;
    int           model_ptr = 0;
    int           accept_cyc = 0, start_cyc = 0, rsp_valid_cyc = 0, hs_cyc = 0;
    int           start_cnt = 0, rsp_cnt = 0;
    logic         rsp_seen = 1'b0;
    logic [W-1:0] last_q = '0;
    logic         last_dbz = 1'b0;
    int           last_id = -1;
    logic [W-1:0] acc_a = '0, acc_b = '0;
    logic [N-1:0] rdy_mask = '1;

    function automatic logic [W-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return W'(sa / sb);
    endfunction

    function automatic logic [W-1:0] rnd_a();
        return W'(int'($urandom_range(0, 200000)) - 100000);
    endfunction

    function automatic logic [W-1:0] rnd_b();
        if ($urandom_range(0, 6) == 0) return '0;
        return W'(int'($urandom_range(0, 100)) - 50);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
    endtask

    task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        set_op(i, a, b);
        req_valid[i] = 1'b1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_dbz_q.delete();
        exp_id_q.delete();
        model_busy = 1'b0;
        model_ptr  = 0;
        rsp_seen   = 1'b0;
    endtask

    // One clock: observe at negedge against the model, then drive after posedge.
    task automatic tick();
        logic [N-1:0] acc;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_v;
        logic [W-1:0] a, b;
        int           w;
        @(negedge clk);
        acc = '0;
        if (div_start) begin
            start_cnt++;
            start_cyc = cyc;
            tests++;
            if (div_dividend !== acc_a || div_divisor !== acc_b) begin
                failed++;
                $display("FAIL div_operands: got %h/%h expected %h/%h", div_dividend, div_divisor, acc_a, acc_b);
            end
        end
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(model_ptr + k) % N]) w = (model_ptr + k) % N;
        if (req_ready !== '0) begin
            exp_rdy = (model_busy || w < 0) ? '0 : (N'(1) << w);
            tests++;
            if (req_ready !== exp_rdy) begin
                failed++;
                $display("FAIL grant: req_ready=%b expected %b at cycle %0d", req_ready, exp_rdy, cyc);
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    acc[i] = 1'b1;
                    a = req_dividend[i*W +: W];
                    b = req_divisor[i*W +: W];
                    grant_log.push_back(i);
                    exp_q.push_back(ref_quot(a, b));
                    exp_dbz_q.push_back(b == '0);
                    exp_id_q.push_back(i);
                    accept_cyc = cyc;
                    acc_a = a;
                    acc_b = b;
                    model_busy = 1'b1;
                end
            end
        end else if (!model_busy && w >= 0) begin
            tests++;
            failed++;
            $display("FAIL grant_missing: req_ready=0 expected one-hot for requester %0d at cycle %0d", w, cyc);
        end
        if (rsp_valid !== '0) begin
            if (!rsp_seen) begin
                rsp_seen = 1'b1;
                rsp_valid_cyc = cyc;
            end
            tests++;
            if (exp_id_q.size() == 0) begin
                failed++;
                $display("FAIL rsp_unexpected: rsp_valid=%b expected 0", rsp_valid);
            end else begin
                exp_v = N'(1) << exp_id_q[0];
                if (rsp_valid !== exp_v) begin
                    failed++;
                    $display("FAIL rsp_valid: got %b expected %b", rsp_valid, exp_v);
                end else if ((rsp_valid & rsp_ready) != '0) begin
                    tests++;
                    if (rsp_quotient !== exp_q[0] || rsp_dbz !== exp_dbz_q[0]) begin
                        failed++;
                        $display("FAIL quotient: got %h dbz %b expected %h dbz %b", rsp_quotient, rsp_dbz, exp_q[0], exp_dbz_q[0]);
                    end
                    last_q   = rsp_quotient;
                    last_dbz = rsp_dbz;
                    last_id  = exp_id_q[0];
                    void'(exp_q.pop_front());
                    void'(exp_dbz_q.pop_front());
                    void'(exp_id_q.pop_front());
                    model_busy = 1'b0;
                    model_ptr  = (last_id + 1) % N;
                    rsp_seen   = 1'b0;
                    hs_cyc     = cyc;
                    rsp_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                req_valid[i] = 1'b0;
                set_op(i, $urandom, $urandom);
            end
        end
        rsp_ready = rdy_mask;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || req_valid !== '0) && n < 3000) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 3000) begin
            failed++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
            req_valid = '0;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rdy_mask  = '1;
        rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_quotient !== '0 || rsp_dbz !== 1'b0 ||
            div_start !== 1'b0 || div_dividend !== '0 || div_divisor !== '0 || dbg_state !== 2'd0) begin
            failed++;
            $display("FAIL %s: rdy=%b rv=%b q=%h dbz=%b st=%b dd=%h dv=%h state=%0d expected all zero",
                     name, req_ready, rsp_valid, rsp_quotient, rsp_dbz, div_start, div_dividend, div_divisor, dbg_state);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        check_reset_values("reset_values");
        @(posedge clk);
        #1;
        clear_model();
        reset = 1'b0;
    endtask

    task automatic test_single();
        int sc;
        div_lat = 34;
        sc = start_cnt;
        post(0, 32'd1000, 32'd7);
        wait_idle("single");
        tests++;
        if (start_cyc !== accept_cyc + 1 || start_cnt - sc !== 1) begin
            failed++;
            $display("FAIL single_start: start at T+%0d count %0d expected T+1 count 1", start_cyc - accept_cyc, start_cnt - sc);
        end
        tests++;
        if (rsp_valid_cyc !== accept_cyc + 36) begin
            failed++;
            $display("FAIL single_latency: rsp_valid at T+%0d expected T+36", rsp_valid_cyc - accept_cyc);
        end
        tests++;
        if (last_q !== 32'd142 || last_dbz !== 1'b0 || last_id !== 0) begin
            failed++;
            $display("FAIL single_result: q=%0d dbz=%b id=%0d expected 142 0 0", last_q, last_dbz, last_id);
        end
    endtask

    task automatic test_contention();
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        do_reset();
        div_lat = 3;
        grant_log.delete();
        post(0, rnd_a(), 32'd9);
        post(1, rnd_a(), 32'hFFFF_FFF9);
        wait_idle("contention1");
        post(0, rnd_a(), 32'd3);
        post(1, rnd_a(), 32'd11);
        wait_idle("contention2");
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (grant_log.size() <= k || grant_log[k] !== exp_order[k]) begin
                failed++;
                $display("FAIL contention_order[%0d]: got %0d expected %0d", k,
                         (grant_log.size() > k) ? grant_log[k] : -1, exp_order[k]);
            end
        end
    endtask

    task automatic test_fairness();
        int c0, n;
        div_lat = 5;
        grant_log.delete();
        post(0, rnd_a(), 32'd13);
        post(1, rnd_a(), 32'd17);
        c0 = rsp_cnt;
        n  = 0;
        while (rsp_cnt == c0 && n < 300) begin
            tick();
            n++;
        end
        post(0, rnd_a(), 32'd19);
        n = 0;
        while (grant_log.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (grant_log.size() < 2 || grant_log[1] !== 1 || accept_cyc !== hs_cyc + 1) begin
            failed++;
            $display("FAIL fairness_next: winner %0d accept at H+%0d expected requester 1 at H+1",
                     (grant_log.size() > 1) ? grant_log[1] : -1, accept_cyc - hs_cyc);
        end
        wait_idle("fairness");
        tests++;
        if (grant_log.size() != 3 || grant_log[2] !== 0) begin
            failed++;
            $display("FAIL fairness_tail: %0d grants, expected 3 ending with requester 0", grant_log.size());
        end
    endtask

    task automatic test_dbz();
        int sc;
        div_lat = 20;
        sc = start_cnt;
        post(2, 32'hFFFF_FFFB, 32'd0);
        wait_idle("dbz_neg");
        tests++;
        if (last_q !== 32'h8000_0000 || last_dbz !== 1'b1 || rsp_valid_cyc !== accept_cyc + 1) begin
            failed++;
            $display("FAIL dbz_neg: q=%h dbz=%b at T+%0d expected 80000000 1 T+1", last_q, last_dbz, rsp_valid_cyc - accept_cyc);
        end
        post(1, 32'd5, 32'd0);
        wait_idle("dbz_pos");
        tests++;
        if (last_q !== 32'h7FFF_FFFF || last_dbz !== 1'b1 || rsp_valid_cyc !== accept_cyc + 1) begin
            failed++;
            $display("FAIL dbz_pos: q=%h dbz=%b at T+%0d expected 7fffffff 1 T+1", last_q, last_dbz, rsp_valid_cyc - accept_cyc);
        end
        tests++;
        if (start_cnt !== sc) begin
            failed++;
            $display("FAIL dbz_start: %0d div_start pulses, expected 0", start_cnt - sc);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] hv;
        logic [W-1:0] hq;
        int           n;
        div_lat  = 4;
        rdy_mask = 3'b110;
        grant_log.delete();
        post(0, 32'd77, 32'hFFFF_FFFD);
        post(1, 32'd9, 32'd2);
        tick();
        n = 0;
        while (rsp_valid === '0 && n < 100) begin
            tick();
            n++;
        end
        hv = rsp_valid;
        hq = rsp_quotient;
        tests++;
        if (hv !== 3'b001 || hq !== 32'hFFFF_FFE7) begin
            failed++;
            $display("FAIL bp_result: rsp_valid=%b q=%h expected 001 ffffffe7", hv, hq);
        end
        repeat (10) begin
            tick();
            tests++;
            if (rsp_valid !== hv || rsp_quotient !== hq || req_ready !== '0) begin
                failed++;
                $display("FAIL bp_hold: rv=%b q=%h rdy=%b expected %b %h 000", rsp_valid, rsp_quotient, req_ready, hv, hq);
            end
        end
        rdy_mask = '1;
        wait_idle("backpressure");
        tests++;
        if (grant_log.size() != 2 || grant_log[1] !== 1 || last_q !== 32'd4) begin
            failed++;
            $display("FAIL bp_release: %0d grants last q=%0d expected 2 grants ending requester 1 q=4", grant_log.size(), last_q);
        end
    endtask

    task automatic test_reset_wait();
        int sc, c0, n;
        div_lat = 30;
        sc = start_cnt;
        post(1, 32'd7000, 32'd3);
        n = 0;
        while (start_cnt == sc && n < 20) begin
            tick();
            n++;
        end
        repeat (5) tick();
        reset     = 1'b1;
        req_valid = '0;
        #2;
        check_reset_values("reset_in_wait");
        @(posedge clk);
        #1;
        clear_model();
        reset = 1'b0;
        c0 = rsp_cnt;
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        repeat (5) tick();
        tests++;
        if (rsp_seen !== 1'b0 || rsp_cnt !== c0 || dbg_state !== 2'd0) begin
            failed++;
            $display("FAIL late_done: rsp_seen=%b state=%0d expected no response and idle", rsp_seen, dbg_state);
        end
        post(1, 32'd7000, 32'd3);
        wait_idle("after_reset");
        tests++;
        if (last_q !== 32'd2333 || last_id !== 1 || last_dbz !== 1'b0) begin
            failed++;
            $display("FAIL after_reset: q=%0d id=%0d expected 2333 1", last_q, last_id);
        end
    endtask

    task automatic test_random();
        int c0;
        div_lat = 0;
        c0 = rsp_cnt;
        for (int it = 0; it < 800; it++) begin
            rdy_mask = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '1;
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 3) == 0) post(i, rnd_a(), rnd_b());
            tick();
        end
        rdy_mask = '1;
        wait_idle("random");
        tests++;
        if (rsp_cnt - c0 < 20) begin
            failed++;
            $display("FAIL random_progress: %0d responses, expected at least 20", rsp_cnt - c0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_dbz();
        test_backpressure();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
